// File: rtl/exc_ctrl.sv
// exc_ctrl: single-level exception/interrupt controller.
// Latches level requests into pending bits and picks the lowest-index
// eligible source. It then walks TAKE -> SERVICE -> RETURN, saving the
// return PC on entry and handing it back on eret.
// Optional feature macro EXC_MASK_EN: when defined, a writable per-source
// enable mask register is built. Otherwise the mask is tied to all ones.
module exc_ctrl #(
  parameter int          NUM_SRC    = 4,
  parameter int          PC_W       = 32,
  parameter logic [31:0] VEC_BASE   = 32'h0000_0180,
  parameter logic [31:0] VEC_STRIDE = 32'h0000_0020,
  localparam int         ID_W       = $clog2(NUM_SRC)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] src,
  input  logic [PC_W-1:0]    pc_next,
  input  logic               done,
  input  logic               mask_we,
  input  logic [NUM_SRC-1:0] mask_wd,
  output logic               take,
  output logic [PC_W-1:0]    vec_addr,
  output logic               ret,
  output logic [PC_W-1:0]    epc,
  output logic [ID_W-1:0]    id,
  output logic               busy,
  output logic [NUM_SRC-1:0] pending
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_TAKE    = 2'd1;
  localparam logic [1:0] ST_SERVICE = 2'd2;
  localparam logic [1:0] ST_RETURN  = 2'd3;

  localparam logic [PC_W-1:0] BASE_W   = PC_W'(VEC_BASE);
  localparam logic [PC_W-1:0] STRIDE_W = PC_W'(VEC_STRIDE);

  logic [1:0]         state_q, state_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [PC_W-1:0]    epc_q, epc_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] pending_clr;
  logic [NUM_SRC-1:0] mask;
  logic [NUM_SRC-1:0] eligible;
  logic [ID_W-1:0]    first_idx;

`ifdef EXC_MASK_EN
  logic [NUM_SRC-1:0] mask_q;

  // Mask register: a write lands on the edge and gates eligibility from the next cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mask_q <= '1;
    end else if (mask_we) begin
      mask_q <= mask_wd;
    end
  end

  assign mask = mask_q;
`else
  logic unused_mask;

  assign mask        = '1;
  assign unused_mask = ^{mask_we, mask_wd};
`endif

  assign eligible = (pending_q | src) & mask;

  // Priority pick: bit 0 wins, so scan downward and let lower indices overwrite
  always_comb begin
    first_idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        first_idx = ID_W'(i);
      end
    end
  end

  // Clear mask for the serviced source, only on the eret edge
  always_comb begin
    pending_clr = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      pending_clr[i] = (state_q == ST_SERVICE) && done && (id_q == ID_W'(i));
    end
  end

  // Next-state logic; new requests always set pending even while the clear fires
  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    epc_d     = epc_q;
    pending_d = (pending_q & ~pending_clr) | src;
    case (state_q)
      ST_IDLE: begin
        if (eligible != '0) begin
          state_d = ST_TAKE;
          id_d    = first_idx;
          epc_d   = pc_next;
        end
      end
      ST_TAKE: begin
        state_d = ST_SERVICE;
      end
      ST_SERVICE: begin
        if (done) begin
          state_d = ST_RETURN;
        end
      end
      ST_RETURN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset abandons any handler in progress
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      id_q      <= '0;
      epc_q     <= '0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      epc_q     <= epc_d;
      pending_q <= pending_d;
    end
  end

  assign take     = (state_q == ST_TAKE);
  assign ret      = (state_q == ST_RETURN);
  assign busy     = (state_q != ST_IDLE);
  assign id       = id_q;
  assign epc      = epc_q;
  assign pending  = pending_q;
  assign vec_addr = BASE_W + PC_W'(id_q) * STRIDE_W;

endmodule

// File: tb/tb_exc_ctrl.sv
// tb_exc_ctrl: directed bench for exc_ctrl with default parameters.
// The mask scenario is compiled in only when EXC_MASK_EN is defined.
module tb_exc_ctrl;

  logic        clk;
  logic        rst;
  logic [3:0]  src;
  logic [31:0] pc_next;
  logic        done;
  logic        mask_we;
  logic [3:0]  mask_wd;
  logic        take;
  logic [31:0] vec_addr;
  logic        ret;
  logic [31:0] epc;
  logic [1:0]  id;
  logic        busy;
  logic [3:0]  pending;

  int total = 0;
  int bad   = 0;

  exc_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .src      (src),
    .pc_next  (pc_next),
    .done     (done),
    .mask_we  (mask_we),
    .mask_wd  (mask_wd),
    .take     (take),
    .vec_addr (vec_addr),
    .ret      (ret),
    .epc      (epc),
    .id       (id),
    .busy     (busy),
    .pending  (pending)
  );

  // 100 MHz free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; src = 4'b0101; pc_next = 32'h0; done = 1'b0;
    mask_we = 1'b0; mask_wd = 4'b0;
    #3;
    total++; if (busy !== 1'b0 || take !== 1'b0 || ret !== 1'b0) begin bad++; $display("[TB] FAIL reset_ctl got busy=%b take=%b ret=%b want 0 0 0", busy, take, ret); end
    total++; if (epc !== 32'h0 || id !== 2'd0) begin bad++; $display("[TB] FAIL reset_regs got epc=%h id=%0d want 0 0", epc, id); end
    step(); step();
    total++; if (pending !== 4'b0000) begin bad++; $display("[TB] FAIL reset_pending got %b want 0000", pending); end
    total++; if (vec_addr !== 32'h0000_0180) begin bad++; $display("[TB] FAIL reset_vec got %h want 00000180", vec_addr); end
    src = 4'b0000;
    rst = 1'b1;
    step();
    total++; if (busy !== 1'b0 || pending !== 4'b0000) begin bad++; $display("[TB] FAIL reset_release got busy=%b pending=%b want 0 0000", busy, pending); end
  endtask

  task automatic test_single();
    src = 4'b0100; pc_next = 32'h0040_0010;
    step();
    src = 4'b0000;
    total++; if (take !== 1'b1 || id !== 2'd2) begin bad++; $display("[TB] FAIL single_take got take=%b id=%0d want 1 2", take, id); end
    total++; if (vec_addr !== 32'h0000_01C0) begin bad++; $display("[TB] FAIL single_vec got %h want 000001c0", vec_addr); end
    total++; if (epc !== 32'h0040_0010) begin bad++; $display("[TB] FAIL single_epc got %h want 00400010", epc); end
    total++; if (pending !== 4'b0100) begin bad++; $display("[TB] FAIL single_pending got %b want 0100", pending); end
    pc_next = 32'h0040_0014;
    step();
    total++; if (take !== 1'b0 || busy !== 1'b1) begin bad++; $display("[TB] FAIL single_service got take=%b busy=%b want 0 1", take, busy); end
    step();
    total++; if (busy !== 1'b1 || ret !== 1'b0 || epc !== 32'h0040_0010) begin bad++; $display("[TB] FAIL single_hold got busy=%b ret=%b epc=%h want 1 0 00400010", busy, ret, epc); end
    done = 1'b1;
    step();
    done = 1'b0;
    total++; if (ret !== 1'b1 || pending !== 4'b0000 || id !== 2'd2) begin bad++; $display("[TB] FAIL single_ret got ret=%b pending=%b id=%0d want 1 0000 2", ret, pending, id); end
    step();
    total++; if (ret !== 1'b0 || busy !== 1'b0) begin bad++; $display("[TB] FAIL single_idle got ret=%b busy=%b want 0 0", ret, busy); end
  endtask

  task automatic test_priority();
    src = 4'b1010; pc_next = 32'h0040_0100;
    step();
    src = 4'b0000; pc_next = 32'h0040_0200;
    total++; if (take !== 1'b1 || id !== 2'd1 || vec_addr !== 32'h0000_01A0) begin bad++; $display("[TB] FAIL prio_first got take=%b id=%0d vec=%h want 1 1 000001a0", take, id, vec_addr); end
    total++; if (pending !== 4'b1010 || epc !== 32'h0040_0100) begin bad++; $display("[TB] FAIL prio_latch got pending=%b epc=%h want 1010 00400100", pending, epc); end
    step();
    done = 1'b1;
    step();
    done = 1'b0;
    total++; if (ret !== 1'b1 || pending !== 4'b1000) begin bad++; $display("[TB] FAIL prio_ret got ret=%b pending=%b want 1 1000", ret, pending); end
    step();
    total++; if (busy !== 1'b0 || take !== 1'b0) begin bad++; $display("[TB] FAIL prio_idle got busy=%b take=%b want 0 0", busy, take); end
    step();
    total++; if (take !== 1'b1 || id !== 2'd3 || vec_addr !== 32'h0000_01E0) begin bad++; $display("[TB] FAIL prio_second got take=%b id=%0d vec=%h want 1 3 000001e0", take, id, vec_addr); end
    total++; if (epc !== 32'h0040_0200) begin bad++; $display("[TB] FAIL prio_epc got %h want 00400200", epc); end
    step();
    done = 1'b1;
    step();
    done = 1'b0;
    total++; if (ret !== 1'b1 || pending !== 4'b0000) begin bad++; $display("[TB] FAIL prio_ret2 got ret=%b pending=%b want 1 0000", ret, pending); end
    step();
  endtask

  task automatic test_back_to_back();
    src = 4'b0100; pc_next = 32'h0040_0300;
    step();
    src = 4'b0000;
    total++; if (take !== 1'b1 || id !== 2'd2) begin bad++; $display("[TB] FAIL nest_take got take=%b id=%0d want 1 2", take, id); end
    step();
    src = 4'b0001;
    step();
    src = 4'b0000;
    total++; if (take !== 1'b0 || busy !== 1'b1 || pending !== 4'b0101 || id !== 2'd2) begin bad++; $display("[TB] FAIL nest_latch got take=%b busy=%b pending=%b id=%0d want 0 1 0101 2", take, busy, pending, id); end
    step(); step();
    total++; if (take !== 1'b0 || id !== 2'd2) begin bad++; $display("[TB] FAIL nest_nopreempt got take=%b id=%0d want 0 2", take, id); end
    done = 1'b1;
    step();
    done = 1'b0; pc_next = 32'h0040_0400;
    total++; if (ret !== 1'b1 || pending !== 4'b0001 || id !== 2'd2 || epc !== 32'h0040_0300) begin bad++; $display("[TB] FAIL nest_ret got ret=%b pending=%b id=%0d epc=%h want 1 0001 2 00400300", ret, pending, id, epc); end
    step();
    total++; if (take !== 1'b0 || busy !== 1'b0) begin bad++; $display("[TB] FAIL nest_idle got take=%b busy=%b want 0 0", take, busy); end
    step();
    total++; if (take !== 1'b1 || id !== 2'd0 || vec_addr !== 32'h0000_0180 || epc !== 32'h0040_0400) begin bad++; $display("[TB] FAIL nest_next got take=%b id=%0d vec=%h epc=%h want 1 0 00000180 00400400", take, id, vec_addr, epc); end
    step();
    done = 1'b1; src = 4'b0001;
    step();
    done = 1'b0; src = 4'b0000;
    total++; if (ret !== 1'b1 || pending !== 4'b0001) begin bad++; $display("[TB] FAIL set_wins got ret=%b pending=%b want 1 0001", ret, pending); end
    step(); step();
    total++; if (take !== 1'b1 || id !== 2'd0) begin bad++; $display("[TB] FAIL set_wins_retake got take=%b id=%0d want 1 0", take, id); end
    step();
    done = 1'b1;
    step();
    done = 1'b0;
    total++; if (ret !== 1'b1 || pending !== 4'b0000) begin bad++; $display("[TB] FAIL set_wins_clear got ret=%b pending=%b want 1 0000", ret, pending); end
    step();
  endtask

  task automatic test_done_idle();
    done = 1'b1;
    step();
    total++; if (busy !== 1'b0 || ret !== 1'b0 || take !== 1'b0) begin bad++; $display("[TB] FAIL done_idle got busy=%b ret=%b take=%b want 0 0 0", busy, ret, take); end
    step();
    total++; if (busy !== 1'b0 || ret !== 1'b0) begin bad++; $display("[TB] FAIL done_idle2 got busy=%b ret=%b want 0 0", busy, ret); end
    done = 1'b0;
  endtask

`ifdef EXC_MASK_EN
  task automatic test_mask();
    mask_we = 1'b1; mask_wd = 4'b1110;
    step();
    mask_we = 1'b0; src = 4'b0001;
    step();
    src = 4'b0000;
    total++; if (pending !== 4'b0001 || take !== 1'b0 || busy !== 1'b0) begin bad++; $display("[TB] FAIL mask_block got pending=%b take=%b busy=%b want 0001 0 0", pending, take, busy); end
    step();
    total++; if (take !== 1'b0 || pending !== 4'b0001) begin bad++; $display("[TB] FAIL mask_hold got take=%b pending=%b want 0 0001", take, pending); end
    mask_we = 1'b1; mask_wd = 4'b1111;
    step();
    mask_we = 1'b0;
    total++; if (take !== 1'b0 || busy !== 1'b0) begin bad++; $display("[TB] FAIL mask_write got take=%b busy=%b want 0 0", take, busy); end
    step();
    total++; if (take !== 1'b1 || id !== 2'd0 || vec_addr !== 32'h0000_0180) begin bad++; $display("[TB] FAIL mask_unmask got take=%b id=%0d vec=%h want 1 0 00000180", take, id, vec_addr); end
    step();
    done = 1'b1;
    step();
    done = 1'b0;
    total++; if (ret !== 1'b1 || pending !== 4'b0000) begin bad++; $display("[TB] FAIL mask_ret got ret=%b pending=%b want 1 0000", ret, pending); end
    step();
  endtask
`endif

  task automatic test_reset_mid();
    src = 4'b0010; pc_next = 32'h0040_0500;
    step();
    src = 4'b1000;
    step();
    src = 4'b0000;
`ifdef EXC_MASK_EN
    mask_we = 1'b1; mask_wd = 4'b0000;
    step();
    mask_we = 1'b0;
`endif
    step();
    total++; if (busy !== 1'b1 || pending !== 4'b1010) begin bad++; $display("[TB] FAIL rstmid_pre got busy=%b pending=%b want 1 1010", busy, pending); end
    #2;
    rst = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || take !== 1'b0 || ret !== 1'b0 || pending !== 4'b0000) begin bad++; $display("[TB] FAIL rstmid_now got busy=%b take=%b ret=%b pending=%b want 0 0 0 0000", busy, take, ret, pending); end
    total++; if (epc !== 32'h0 || id !== 2'd0 || vec_addr !== 32'h0000_0180) begin bad++; $display("[TB] FAIL rstmid_regs got epc=%h id=%0d vec=%h want 0 0 00000180", epc, id, vec_addr); end
    done = 1'b1;
    step();
    total++; if (ret !== 1'b0 || busy !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_noret got ret=%b busy=%b want 0 0", ret, busy); end
    rst = 1'b1; done = 1'b0;
    step();
    total++; if (ret !== 1'b0 || busy !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_after got ret=%b busy=%b want 0 0", ret, busy); end
    src = 4'b0001;
    step();
    src = 4'b0000;
    total++; if (take !== 1'b1 || id !== 2'd0) begin bad++; $display("[TB] FAIL rstmid_mask got take=%b id=%0d want 1 0", take, id); end
    step();
    done = 1'b1;
    step();
    done = 1'b0;
    step();
  endtask

  // Run every scenario in order, then report
  initial begin
    test_reset();
    test_single();
    test_priority();
    test_back_to_back();
    test_done_idle();
`ifdef EXC_MASK_EN
    test_mask();
`endif
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
